// File: rtl/umai_master.sv
// umai_master: replays AIB channel commands/write data as a UMAI master and splits UMAI read beats back onto AIB lanes
module umai_master #(
  parameter int NumChannels = 6
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [2:0]                       c_first_chn_id,
  input  logic [2:0]                       c_last_chn_id,
  output logic                             o_umai_wcmd_valid,
  input  logic                             i_umai_wcmd_ready,
  output logic [31:0]                      o_umai_wcmd_addr,
  output logic [5:0]                       o_umai_wcmd_len,
  output logic                             o_umai_rcmd_valid,
  input  logic                             i_umai_rcmd_ready,
  output logic [31:0]                      o_umai_rcmd_addr,
  output logic [5:0]                       o_umai_rcmd_len,
  output logic                             o_umai_wvalid,
  input  logic                             i_umai_wready,
  output logic [511:0]                     o_umai_wdata,
  input  logic                             i_umai_rvalid,
  output logic                             o_umai_rready,
  input  logic [511:0]                     i_umai_rdata,
  input  logic [NumChannels-1:0]           i_rx_valid,
  output logic [NumChannels-1:0]           o_rx_ready,
  input  logic [NumChannels-1:0][71:0]     i_rx_data,
  output logic [NumChannels-1:0]           o_tx_valid,
  input  logic [NumChannels-1:0]           i_tx_ready,
  output logic [NumChannels-1:0][71:0]     o_tx_data,
  output logic                             o_proto_err
);
  logic                       legal, cmd_here, sel_rdy, cmd_ok, wr_go, drop, rx_all, tx_all, tx_go, last_tx, hv;
  logic [3:0]                 n, wcnt, wpos, rptr, idx;
  logic [2:0]                 k;
  logic [71:0]                cw;
  logic [NumChannels-1:0]     mask, first;
  logic [7:0][63:0]           wbuf, wbuf_n, rbuf;
  logic [1:0]                 fpush, fpop, fready;
  logic [1:0]                 fcnt [2];
  logic [1:0][37:0]           fm [2];
  always_comb begin
    legal = c_first_chn_id <= c_last_chn_id && {1'b0, c_last_chn_id} < 4'(NumChannels);
    n = {1'b0, c_last_chn_id} - {1'b0, c_first_chn_id} + 4'd1;
    cw = '0;
    rx_all = legal;
    tx_all = legal;
    for (int i = 0; i < NumChannels; i++) begin
      mask[i] = legal && 3'(i) >= c_first_chn_id && 3'(i) <= c_last_chn_id;
      first[i] = legal && 3'(i) == c_first_chn_id;
      if (first[i]) cw = i_rx_data[i];
      if (mask[i] && !i_rx_valid[i]) rx_all = 1'b0;
      if (mask[i] && !i_tx_ready[i]) tx_all = 1'b0;
    end
  end
  // Two 38-bit {len,addr} FIFOs of depth 2: index 0 holds write commands, 1 read commands
  always_comb begin
    fpop[0] = fcnt[0] != 2'd0 && i_umai_wcmd_ready;
    fpop[1] = fcnt[1] != 2'd0 && i_umai_rcmd_ready;
    fready[0] = fcnt[0] != 2'd2 || fpop[0];
    fready[1] = fcnt[1] != 2'd2 || fpop[1];
    cmd_here = |(first & i_rx_valid) && cw[71];
    sel_rdy = cw[70] ? fready[0] : fready[1];
    cmd_ok = cmd_here && sel_rdy;
    fpush = {cmd_ok && !cw[70], cmd_ok && cw[70]};
  end
  for (genvar g = 0; g < 2; g++) begin : g_fifo
    always_ff @(posedge i_clk)
      if (i_rst) begin
        fcnt[g] <= '0;
        fm[g] <= '0;
      end else begin
        if (fpop[g]) fm[g][0] <= fm[g][1];
        if (fpush[g]) fm[g][fcnt[g][1] | (fcnt[g][0] & ~fpop[g])] <= cw[37:0];
        fcnt[g] <= fcnt[g] + 2'(fpush[g]) - 2'(fpop[g]);
      end
  end
  assign o_umai_wcmd_valid = fcnt[0] != 2'd0;
  assign o_umai_rcmd_valid = fcnt[1] != 2'd0;
  assign {o_umai_wcmd_len, o_umai_wcmd_addr} = fm[0][0];
  assign {o_umai_rcmd_len, o_umai_rcmd_addr} = fm[1][0];
  // Valid lanes pack into consecutive slots; once slot 7 is taken further lanes are dropped
  always_comb begin
    wr_go = legal && !cmd_here && rx_all && !wcnt[3];
    wbuf_n = wbuf;
    wpos = wcnt;
    drop = 1'b0;
    for (int i = 0; i < NumChannels; i++)
      if (mask[i] && i_rx_data[i][64]) begin
        if (wpos[3]) drop = 1'b1;
        else begin
          wbuf_n[wpos[2:0]] = i_rx_data[i][63:0];
          wpos = wpos + 4'd1;
        end
      end
  end
  assign o_rx_ready = i_rst ? '0 : cmd_here ? (sel_rdy ? first : '0) : wr_go ? mask : '0;
  assign o_umai_wvalid = wcnt[3];
  assign o_umai_wdata = wbuf;
  always_comb begin
    tx_go = hv && tx_all;
    last_tx = tx_go && rptr + n >= 4'd8;
    o_umai_rready = !i_rst && (!hv || last_tx);
    k = '0;
    idx = '0;
    for (int i = 0; i < NumChannels; i++) begin
      k = 3'(i) - c_first_chn_id;
      idx = rptr + {1'b0, k};
      o_tx_valid[i] = tx_go && mask[i];
      o_tx_data[i] = (tx_go && mask[i] && idx < 4'd8) ? {8'h01, rbuf[idx[2:0]]} : '0;
    end
  end
  always_ff @(posedge i_clk)
    if (i_rst) begin
      wcnt <= '0;
      wbuf <= '0;
      rbuf <= '0;
      rptr <= '0;
      hv <= 1'b0;
      o_proto_err <= 1'b0;
    end else begin
      if (wr_go) begin
        wbuf <= wbuf_n;
        wcnt <= wpos;
      end else if (o_umai_wvalid && i_umai_wready) wcnt <= '0;
      if (i_umai_rvalid && o_umai_rready) begin
        rbuf <= i_umai_rdata;
        rptr <= '0;
        hv <= 1'b1;
      end else if (tx_go) begin
        rptr <= rptr + n;
        if (last_tx) hv <= 1'b0;
      end
      if ((wr_go && drop) || (cmd_ok && |cw[69:38])) o_proto_err <= 1'b1;
    end
endmodule

// File: tb/tb_umai_master.sv
// tb_umai_master: randomized bench comparing umai_master against a queue/array reference model
module tb_umai_master;
  localparam int NC = 6;
  logic                 clk = 1'b0, rst = 1'b1;
  logic [2:0]           f = 3'd0, l = 3'd5;
  logic                 wcmd_valid, wcmd_ready, rcmd_valid, rcmd_ready;
  logic [31:0]          wcmd_addr, rcmd_addr;
  logic [5:0]           wcmd_len, rcmd_len;
  logic                 wvalid, wready, rvalid, rready, proto_err;
  logic [511:0]         wdata, rdata;
  logic [NC-1:0]        rx_valid, rx_ready, tx_valid, tx_ready;
  logic [NC-1:0][71:0]  rx_data, tx_data;
  int                   errors = 0, checks = 0;
  logic [37:0]          wq[$], rq[$];
  logic [63:0]          ww[8], rw[8];
  int                   wn = 0, rp = 0;
  bit                   rh = 0, err = 0;
  logic [2:0]           cfs[8] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd3, 3'd4, 3'd0, 3'd5};
  logic [2:0]           cls[8] = '{3'd5, 3'd3, 3'd2, 3'd0, 3'd5, 3'd2, 3'd7, 3'd5};

  umai_master #(.NumChannels(NC)) dut (
    .i_clk(clk), .i_rst(rst), .c_first_chn_id(f), .c_last_chn_id(l),
    .o_umai_wcmd_valid(wcmd_valid), .i_umai_wcmd_ready(wcmd_ready),
    .o_umai_wcmd_addr(wcmd_addr), .o_umai_wcmd_len(wcmd_len),
    .o_umai_rcmd_valid(rcmd_valid), .i_umai_rcmd_ready(rcmd_ready),
    .o_umai_rcmd_addr(rcmd_addr), .o_umai_rcmd_len(rcmd_len),
    .o_umai_wvalid(wvalid), .i_umai_wready(wready), .o_umai_wdata(wdata),
    .i_umai_rvalid(rvalid), .o_umai_rready(rready), .i_umai_rdata(rdata),
    .i_rx_valid(rx_valid), .o_rx_ready(rx_ready), .i_rx_data(rx_data),
    .o_tx_valid(tx_valid), .i_tx_ready(tx_ready), .o_tx_data(tx_data),
    .o_proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NC; i++) begin
      rx_valid[i] = $urandom_range(0, 99) < 88;
      rx_data[i] = {7'b0, ($urandom_range(0, 99) < 80), $urandom, $urandom};
      tx_ready[i] = $urandom_range(0, 99) < 85;
    end
    if (f < NC && $urandom_range(0, 4) == 0)
      rx_data[f] = {1'b1, 1'($urandom), ($urandom_range(0, 15) == 0) ? 32'($urandom) : 32'h0,
                    6'($urandom), 32'($urandom)};
    wcmd_ready = $urandom_range(0, 99) < 70;
    rcmd_ready = $urandom_range(0, 99) < 70;
    wready = $urandom_range(0, 99) < 60;
    rvalid = $urandom_range(0, 99) < 50;
    for (int i = 0; i < 16; i++) rdata[i*32 +: 32] = $urandom;
  endtask

  task automatic model();
    bit legal = (f <= l) && (l < NC);
    int n = int'(l) - int'(f) + 1;
    bit all_rx = legal, all_tx = legal, cmd = 0, ok, wpop, rpop, fire, last, drain, wr_ok;
    logic [71:0] cw = '0;
    logic [NC-1:0] mask = '0, e_rxr = '0, e_txv = '0;
    logic [NC-1:0][71:0] e_txd = '0;
    logic [511:0] e_wd = '0;
    if (legal) begin
      cw = rx_data[f];
      cmd = rx_valid[f] && cw[71];
      for (int i = f; i <= l; i++) begin
        mask[i] = 1'b1;
        all_rx &= rx_valid[i];
        all_tx &= tx_ready[i];
      end
    end
    chk("wcmd_valid", wcmd_valid, wq.size() != 0);
    if (wq.size() != 0) chk("wcmd", {wcmd_len, wcmd_addr}, wq[0]);
    chk("rcmd_valid", rcmd_valid, rq.size() != 0);
    if (rq.size() != 0) chk("rcmd", {rcmd_len, rcmd_addr}, rq[0]);
    chk("wvalid", wvalid, wn == 8);
    if (wn == 8) begin
      for (int k = 0; k < 8; k++) e_wd[k*64 +: 64] = ww[k];
      chk("wdata", wdata, e_wd);
    end
    chk("proto_err", proto_err, err);
    fire = rh && all_tx;
    last = fire && rp + n >= 8;
    chk("rready", rready, !rh || last);
    if (fire)
      for (int i = f; i <= l; i++) begin
        e_txv[i] = 1'b1;
        if (rp + i - f < 8) e_txd[i] = {8'h01, rw[rp + i - f]};
      end
    chk("tx_valid", tx_valid, e_txv);
    chk("tx_data", tx_data, e_txd);
    // state advance
    wpop = wq.size() != 0 && wcmd_ready;
    rpop = rq.size() != 0 && rcmd_ready;
    ok = cw[70] ? (wq.size() < 2 || wpop) : (rq.size() < 2 || rpop);
    drain = wn == 8 && wready;
    wr_ok = all_rx && wn < 8;
    if (wpop) void'(wq.pop_front());
    if (rpop) void'(rq.pop_front());
    if (cmd) begin
      e_rxr[f] = ok;
      if (ok) begin
        if (cw[70]) wq.push_back(cw[37:0]);
        else rq.push_back(cw[37:0]);
        if (cw[69:38] != 0) err = 1;
      end
    end else if (wr_ok) begin
      e_rxr = mask;
      for (int i = f; i <= l; i++)
        if (rx_data[i][64]) begin
          if (wn < 8) ww[wn++] = rx_data[i][63:0];
          else err = 1;
        end
    end
    if (drain) wn = 0;
    chk("rx_ready", rx_ready, e_rxr);
    if (rvalid && (!rh || last)) begin
      for (int k = 0; k < 8; k++) rw[k] = rdata[k*64 +: 64];
      rp = 0;
      rh = 1;
    end else if (fire) begin
      rp += n;
      if (last) rh = 0;
    end
  endtask

  task automatic do_reset(input logic [2:0] nf, input logic [2:0] nl);
    @(negedge clk);
    rst = 1'b1;
    f = nf;
    l = nl;
    drive();
    @(posedge clk);
    wq.delete();
    rq.delete();
    wn = 0;
    rp = 0;
    rh = 0;
    err = 0;
    @(negedge clk);
    drive();
    #1;
    chk("rst_ctl", {wcmd_valid, rcmd_valid, wvalid, rready, rx_ready, tx_valid, proto_err}, '0);
    chk("rst_cmd", {wcmd_addr, wcmd_len, rcmd_addr, rcmd_len}, '0);
    chk("rst_wdata", wdata, '0);
    chk("rst_tx", tx_data, '0);
    @(posedge clk);
  endtask

  initial begin
    drive();
    repeat (2) @(posedge clk);
    for (int c = 0; c < 8; c++) begin
      do_reset(cfs[c], cls[c]);
      repeat (400) begin
        @(negedge clk);
        rst = 1'b0;
        drive();
        #1;
        model();
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
